sprite_write_scheduler: RTL and testbench

SPRITE_WRITE_SCHEDULER -- requirements
Module: sprite_write_scheduler

---
 rtl/sprite_write_scheduler_pkg.sv | 13 +
 rtl/sprite_cmd_fifo.sv | 38 +++
 rtl/sprite_write_scheduler.sv | 68 ++++++
 tb/tb_sprite_write_scheduler.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sprite_write_scheduler_pkg.sv
// sprite_write_scheduler_pkg: shared widths, command record and FSM encoding
package sprite_write_scheduler_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int ID_W = 8;
  localparam int CMD_W = X_W + Y_W + ID_W;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [ID_W-1:0] id;
  } sprite_cmd_t;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
endpackage

// File: rtl/sprite_cmd_fifo.sv
// sprite_cmd_fifo: first-word fall-through command queue with flush that can retain the head
module sprite_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     keep_head,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  // a flush keeps only the head that the writer is still using
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= rd_ptr + AW'(keep_head);
      count <= CW'(keep_head && !pop);
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/sprite_write_scheduler.sv
// sprite_write_scheduler: queues sprite updates and writes them to graphics RAM during vblank
module sprite_write_scheduler
  import sprite_write_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC = 1
) (
  input  logic                         ppu_fclk,
  input  logic                         ppu_rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [X_W-1:0]               cmd_x,
  input  logic [Y_W-1:0]               cmd_y,
  input  logic [ID_W-1:0]              cmd_id,
  input  logic                         vblank,
  input  logic                         flush,
  output logic                         ppu_wrn,
  output logic [X_W-1:0]               ppu_sprite_x,
  output logic [Y_W-1:0]               ppu_sprite_y,
  output logic [ID_W-1:0]              ppu_sprite_id,
  output logic [$clog2(FIFO_DEPTH):0]  pending,
  output logic                         busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  sprite_cmd_t bus;
  logic [CMD_W-1:0] head;
  logic [1:0] setup_cnt;
  logic live, start, enter;
  sprite_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk(ppu_fclk),
    .rst(ppu_rst),
    .push(cmd_valid && cmd_ready),
    .pop(state == STROBE),
    .flush(flush),
    .keep_head(state == SETUP || state == STROBE),
    .push_data({cmd_x, cmd_y, cmd_id}),
    .head(head),
    .count(pending)
  );
  assign cmd_ready = live && (pending < CW'(FIFO_DEPTH)) && !flush;
  assign start = (pending != '0) && vblank && !flush;
  assign enter = start && (state == IDLE || state == HOLD);
  assign ppu_wrn = state != STROBE;
  assign busy = state != IDLE;
  assign ppu_sprite_x = bus.x;
  assign ppu_sprite_y = bus.y;
  assign ppu_sprite_id = bus.id;
  always_comb begin
    state_n = state;
    state_n = state == SETUP  ? (setup_cnt == 2'(SETUP_CYC - 1) ? STROBE : SETUP) :
              state == STROBE ? HOLD :
              enter           ? SETUP : IDLE;
  end
  // live gates cmd_ready until the first edge after reset release
  always_ff @(posedge ppu_fclk or posedge ppu_rst)
    if (ppu_rst) begin
      state <= IDLE;
      setup_cnt <= '0;
      live <= 1'b0;
      bus <= '0;
    end else begin
      state <= state_n;
      live <= 1'b1;
      setup_cnt <= state == SETUP ? setup_cnt + 2'd1 : 2'd0;
      if (enter) bus <= sprite_cmd_t'(head);
    end
endmodule

// File: tb/tb_sprite_write_scheduler.sv
// tb_sprite_write_scheduler: directed and random stimulus checked against a queue-based write model
module tb_sprite_write_scheduler;
  localparam int FIFO_DEPTH = 4;
  localparam int SETUP_CYC = 1;
  logic ppu_fclk, ppu_rst, cmd_valid, cmd_ready, vblank, flush, ppu_wrn, busy;
  logic [9:0] cmd_x, ppu_sprite_x;
  logic [8:0] cmd_y, ppu_sprite_y;
  logic [7:0] cmd_id, ppu_sprite_id;
  logic [2:0] pending;
  int checks, errors;
  logic [26:0] q[$];
  logic [26:0] cur;
  bit busy_m, live_m;
  int ph;

  sprite_write_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .SETUP_CYC(SETUP_CYC)) dut (
    .ppu_fclk(ppu_fclk), .ppu_rst(ppu_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_id(cmd_id), .vblank(vblank), .flush(flush),
    .ppu_wrn(ppu_wrn), .ppu_sprite_x(ppu_sprite_x), .ppu_sprite_y(ppu_sprite_y),
    .ppu_sprite_id(ppu_sprite_id), .pending(pending), .busy(busy)
  );

  initial ppu_fclk = 1'b0;
  always #5 ppu_fclk = ~ppu_fclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return live_m && q.size() < FIFO_DEPTH && !flush;
  endfunction

  // writer phases: 0..SETUP_CYC-1 setup, SETUP_CYC strobe, SETUP_CYC+1 hold
  task automatic model_step();
    int n0;
    bit b0, pop, keep, start, acc;
    logic [26:0] h;
    if (ppu_rst) begin
      q.delete(); busy_m = 0; ph = 0; cur = '0; live_m = 0;
      return;
    end
    n0 = q.size();
    b0 = busy_m;
    h = n0 > 0 ? q[0] : '0;
    pop = b0 && ph == SETUP_CYC;
    keep = b0 && ph < SETUP_CYC;
    start = (!b0 || ph == SETUP_CYC + 1) && n0 > 0 && vblank && !flush;
    acc = cmd_valid && exp_ready();
    if (flush) begin
      if (keep) q = {h}; else q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({cmd_x, cmd_y, cmd_id});
    end
    if (start) begin cur = h; busy_m = 1; ph = 0; end
    else if (b0) begin
      if (ph == SETUP_CYC + 1) busy_m = 0; else ph++;
    end
    live_m = 1;
  endtask

  task automatic compare_all();
    check("ready", cmd_ready, exp_ready());
    check("wrn", ppu_wrn, !(busy_m && ph == SETUP_CYC));
    check("busy", busy, busy_m);
    check("pending", pending, q.size());
    check("x", ppu_sprite_x, cur[26:17]);
    check("y", ppu_sprite_y, cur[16:8]);
    check("id", ppu_sprite_id, cur[7:0]);
  endtask

  task automatic tick();
    @(posedge ppu_fclk);
    model_step();
    @(negedge ppu_fclk);
    compare_all();
  endtask

  task automatic push(input logic [9:0] x, input logic [8:0] y, input logic [7:0] id);
    cmd_valid = 1; cmd_x = x; cmd_y = y; cmd_id = id;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 20 && ppu_wrn !== 1'b0; i++) tick();
    check("reach_strobe", ppu_wrn, 1'b0);
  endtask

  int ns;
  initial begin
    checks = 0; errors = 0;
    busy_m = 0; live_m = 0; ph = 0; cur = '0;
    ppu_rst = 1; cmd_valid = 0; cmd_x = '0; cmd_y = '0; cmd_id = '0; vblank = 0; flush = 0;
    #1;
    check("rst_wrn", ppu_wrn, 1'b1);
    check("rst_ready", cmd_ready, 1'b0);
    repeat (2) tick();
    ppu_rst = 0;
    tick();
    check("ready_after_rst", cmd_ready, 1'b1);
    // single write
    vblank = 1;
    push(10'd100, 9'd50, 8'd7);
    repeat (6) tick();
    // fill while blanked off, then drain
    vblank = 0;
    for (int i = 0; i < 5; i++) push(10'(i + 1), 9'(i * 3), 8'(i + 20));
    check("full_pending", pending, 3'd4);
    vblank = 1;
    ns = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ppu_wrn === 1'b0) ns++;
    end
    check("strobes", ns, 4);
    // vblank falls right after SETUP entry
    vblank = 0;
    push(10'd11, 9'd12, 8'd13);
    push(10'd21, 9'd22, 8'd23);
    vblank = 1;
    tick();
    vblank = 0;
    repeat (8) tick();
    vblank = 1;
    repeat (6) tick();
    // flush during STROBE
    vblank = 0;
    for (int i = 0; i < 3; i++) push(10'(300 + i), 9'(i), 8'(i + 90));
    vblank = 1;
    wait_strobe();
    flush = 1;
    tick();
    flush = 0;
    repeat (6) tick();
    check("flush_pending", pending, 3'd0);
    // asynchronous reset during STROBE
    vblank = 0;
    push(10'd500, 9'd400, 8'd200);
    push(10'd501, 9'd401, 8'd201);
    vblank = 1;
    wait_strobe();
    #2 ppu_rst = 1;
    #1;
    check("arst_wrn", ppu_wrn, 1'b1);
    check("arst_pending", pending, 3'd0);
    check("arst_x", ppu_sprite_x, 10'd0);
    check("arst_busy", busy, 1'b0);
    tick();
    ppu_rst = 0;
    tick();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = $urandom_range(0, 1);
      cmd_x = 10'($urandom); cmd_y = 9'($urandom); cmd_id = 8'($urandom);
      if ($urandom_range(0, 9) == 0) vblank = ~vblank;
      flush = $urandom_range(0, 39) == 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
